serial_frame_receiver: RTL and testbench
========================================

# serial_frame_receiver

Bit-serial frame receiver that sits directly downstream of the preset/clear D flip-flop stage. It consumes that stage's complementary output pair (true and inverted bit) and checks the pair on every clock. It hunts for a 4-bit sync pattern, then deserialises the next DW data bits MSB-first and presents the assembled word to a consumer over a VALID/OUT_RDY handshake. Complement violations and overruns are flagged.

## Interface
Parameters:
- SYNC, 4'b1101, sync pattern; first-received bit is the MSB
- DW, 8, data bits per frame (2..16)

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- CLR  in  1  reset; asynchronous, active-low
- DIN  in  1  serial bit, true rail (upstream flop QN)
- DINF  in  1  serial bit, complement rail (upstream flop QNF)
- OUT_RDY  in  1  consumer ready
- DATA  out  DW  received word; held stable while VALID=1
- VALID  out  1  DATA holds an unconsumed word
- ERR  out  1  one-cycle pulse on a complement violation
- OVR  out  1  sticky overrun flag; cleared only by CLR
- FRM_CNT  out  4  count of words accepted by the consumer; wraps 15->0

## Operation
- The bit is sampled as DIN on every rising CLK edge.
- A bit is illegal when DIN==DINF. An illegal bit causes:
  - ERR=1 for the following cycle.
  - The FSM goes to HUNT, and the window and fill count are cleared.
  - Any partial word is discarded.
  - The DATA/VALID output register is untouched.
- The FSM has two states:
  - HUNT: shift DIN into the 4-bit window and increment the fill count, saturating at 4. When the fill count is 4 and the window equals SYNC, go to DATA and set the bit count to 0. The fill count prevents a match against the reset-cleared window, even when SYNC=4'b0000.
  - DATA: shift DIN into the DW-bit register and increment the bit count. On the DW-th bit:
    - Complete the word.
    - Return to HUNT.
    - Clear the window and fill count, so sync windows never overlap data bits.
- On word completion:
  - If VALID=0, or VALID=1 and OUT_RDY=1 on that same edge, load DATA and set VALID=1.
  - Otherwise drop the new word, set OVR=1, and leave DATA and VALID unchanged.
- Handshake: a word is accepted on an edge where VALID=1 and OUT_RDY=1.
  - On acceptance, FRM_CNT increments.
  - VALID clears, unless a new word loads on the same edge; in that case VALID stays 1.
- OUT_RDY while VALID=0 has no effect.
- Reset values: state HUNT, window 0, fill count 0, bit count 0, DATA 0, VALID 0, ERR 0, OVR 0, FRM_CNT 0.

## Timing
- Assertion of CLR clears all state immediately, without waiting for CLK, including mid-frame and while VALID=1. State holds while CLR=0.
- Take edge k as the edge that samples the last sync bit:
  - The first data bit is sampled at edge k+1.
  - DATA and VALID are visible after edge k+DW.
  - Minimum frame length is 4+DW cycles.
- ERR is registered: it is high for exactly one cycle after the edge that sampled the illegal bit.
- Back-to-back frames are allowed: sync may start on the edge immediately after the last data bit.
- No combinational path from any input to any output.

## Structure
- Package serial_frame_pkg holds:
  - the state enum (HUNT, DATA)
  - the default SYNC and DW constants
  - the fill-count width
- One sub-module, shift_reg_sipo: a parameterised serial-in/parallel-out shift register with CLK, async active-low CLR, shift enable and synchronous clear. It is instantiated twice, once for the 4-bit window and once for the DW-bit data register.

## Test plan
- Sync detect and load: CLR pulse, then stream 1,1,0,1 followed by 1010_0101 with OUT_RDY=1. Required: VALID=1 with DATA=8'hA5 after the 12th edge, FRM_CNT=1 one edge later, ERR=0, OVR=0.
- Backpressure and overrun: hold OUT_RDY=0 and send two complete frames (8'h3C, then 8'hFF). Required: DATA stays 8'h3C, OVR=1 after frame 2 completes, VALID stays 1, FRM_CNT=0.
- Simultaneous accept and load: VALID=1 holding 8'h11, and OUT_RDY=1 on the same edge that completes 8'h22. Required: DATA=8'h22, VALID stays 1, FRM_CNT increments by 1, OVR=0.
- Complement violation: drive DIN=DINF=1 on data bit 3. Required: ERR high for exactly 1 cycle, no word produced, the next clean frame 8'h5A is received correctly.
- Reset mid-frame: assert CLR during data bit 5. Required: all outputs return to reset values without a clock edge, and a fresh frame after release decodes correctly.
- Wrap and zero-sync: 16 accepted frames return FRM_CNT to 0. With SYNC=4'b0000, no match occurs before 4 bits have been shifted in after reset.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared types and defaults for the serial frame receiver.
package serial_frame_pkg;
  typedef enum logic {ST_HUNT = 1'b0, ST_DATA = 1'b1} state_t;

  localparam logic [3:0] SYNC_DEFAULT = 4'b1101;
  localparam int DW_DEFAULT = 8;

  // Fill count runs 0..4, so three bits.
  localparam int FILL_W = 3;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(4);
endpackage

// File: rtl/shift_reg_sipo.sv
// Serial-in/parallel-out shift register, MSB-first; sync clear wins over shift.
module shift_reg_sipo #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         i_shift_en,
  input  logic         i_sync_clr,
  input  logic         i_din,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_q <= '0;
    end else if (i_sync_clr) begin
      r_q <= '0;
    end else if (i_shift_en) begin
      r_q <= {r_q[W-2:0], i_din};
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/serial_frame_receiver.sv
// Bit-serial receiver: checks the complementary rail pair, hunts for SYNC,
// deserialises DW bits MSB-first and offers the word over VALID/OUT_RDY.
module serial_frame_receiver import serial_frame_pkg::*; #(
  parameter logic [3:0] SYNC = SYNC_DEFAULT,
  parameter int         DW   = DW_DEFAULT
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          DIN,
  input  logic          DINF,
  input  logic          OUT_RDY,
  output logic [DW-1:0] DATA,
  output logic          VALID,
  output logic          ERR,
  output logic          OVR,
  output logic [3:0]    FRM_CNT,
  output state_t        DBG_STATE
);
  localparam int CNT_W = $clog2(DW);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DW - 1);

  state_t            r_state, w_state_nxt;
  logic [FILL_W-1:0] r_fill, w_fill_nxt;
  logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;

  logic [3:0]        w_win;
  logic [3:0]        w_win_shifted;
  logic [DW-1:0]     w_shift_q;
  logic [DW-1:0]     w_word;
  logic              w_illegal;
  logic              w_win_shift, w_win_clr;
  logic              w_dat_shift, w_dat_clr;
  logic              w_complete;
  logic              w_unused_msbs;

  logic [DW-1:0]     r_data;
  logic              r_valid, r_err, r_ovr;
  logic [3:0]        r_frm_cnt;

  assign w_illegal     = (DIN == DINF);
  // Decisions use the register contents including the bit arriving this edge.
  assign w_win_shifted = {w_win[2:0], DIN};
  assign w_word        = {w_shift_q[DW-2:0], DIN};
  assign w_unused_msbs = w_win[3] ^ w_shift_q[DW-1];

  shift_reg_sipo #(.W(4)) u_window (
    .CLK        (CLK),
    .CLR        (CLR),
    .i_shift_en (w_win_shift),
    .i_sync_clr (w_win_clr),
    .i_din      (DIN),
    .o_q        (w_win)
  );

  shift_reg_sipo #(.W(DW)) u_data (
    .CLK        (CLK),
    .CLR        (CLR),
    .i_shift_en (w_dat_shift),
    .i_sync_clr (w_dat_clr),
    .i_din      (DIN),
    .o_q        (w_shift_q)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state   <= ST_HUNT;
      r_fill    <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_fill    <= w_fill_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_fill_nxt    = r_fill;
    w_bit_cnt_nxt = r_bit_cnt;
    w_win_shift   = 1'b0;
    w_win_clr     = 1'b0;
    w_dat_shift   = 1'b0;
    w_dat_clr     = 1'b0;
    w_complete    = 1'b0;
    if (w_illegal) begin
      w_state_nxt   = ST_HUNT;
      w_fill_nxt    = '0;
      w_bit_cnt_nxt = '0;
      w_win_clr     = 1'b1;
      w_dat_clr     = 1'b1;
    end else begin
      case (r_state)
        ST_HUNT: begin
          w_win_shift = 1'b1;
          if (r_fill != FILL_FULL) w_fill_nxt = r_fill + 1'b1;
          // Window is only trusted once four real bits have been shifted in.
          if (r_fill >= FILL_FULL - 1'b1 && w_win_shifted == SYNC) begin
            w_state_nxt   = ST_DATA;
            w_bit_cnt_nxt = '0;
          end
        end
        ST_DATA: begin
          w_dat_shift   = 1'b1;
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            w_complete    = 1'b1;
            w_state_nxt   = ST_HUNT;
            w_fill_nxt    = '0;
            w_bit_cnt_nxt = '0;
            w_win_clr     = 1'b1;
          end
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end
  end

  // VALID/OUT_RDY: a word transfers on any edge with VALID=1 and OUT_RDY=1.
  // DATA is frozen while VALID=1, except that a word completing on a transfer
  // edge loads in place (VALID stays 1); completing on any other VALID=1 edge
  // drops the word and sets the sticky OVR.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_ovr     <= 1'b0;
      r_frm_cnt <= '0;
    end else begin
      r_err <= w_illegal;
      if (r_valid && OUT_RDY) begin
        r_frm_cnt <= r_frm_cnt + 1'b1;
        r_valid   <= 1'b0;
      end
      if (w_complete) begin
        if (!r_valid || OUT_RDY) begin
          r_data  <= w_word;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end
    end
  end

  assign DATA      = r_data;
  assign VALID     = r_valid;
  assign ERR       = r_err;
  assign OVR       = r_ovr;
  assign FRM_CNT   = r_frm_cnt;
  assign DBG_STATE = r_state;
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed and randomized bench for serial_frame_receiver, checked against a
// bit-history reference model.
module tb_serial_frame_receiver;
  import serial_frame_pkg::*;

  localparam int DW = 8;
  localparam logic [3:0] SYNC = 4'b1101;

  logic          CLK = 1'b0;
  logic          CLR = 1'b0;
  logic          DIN = 1'b0;
  logic          DINF = 1'b1;
  logic          OUT_RDY = 1'b0;
  logic [DW-1:0] DATA;
  logic          VALID, ERR, OVR;
  logic [3:0]    FRM_CNT;
  state_t        DBG_STATE;

  logic          DIN2 = 1'b1;
  logic          DINF2 = 1'b0;
  logic [DW-1:0] DATA2;
  logic          VALID2, ERR2, OVR2;
  logic [3:0]    FRM_CNT2;
  state_t        DBG_STATE2;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  // reference model state
  bit            m_hist[$];
  bit            m_bits[$];
  bit            m_in_data;
  logic [DW-1:0] m_data;
  bit            m_valid, m_err, m_ovr;
  int            m_frm;

  // scoreboard of words expected at consumer acceptance
  logic [DW-1:0] exp_q[$];
  bit            sb_on = 1'b0;

  // clock / reset block
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  serial_frame_receiver #(.SYNC(SYNC), .DW(DW)) u_dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .DIN       (DIN),
    .DINF      (DINF),
    .OUT_RDY   (OUT_RDY),
    .DATA      (DATA),
    .VALID     (VALID),
    .ERR       (ERR),
    .OVR       (OVR),
    .FRM_CNT   (FRM_CNT),
    .DBG_STATE (DBG_STATE)
  );

  serial_frame_receiver #(.SYNC(4'b0000), .DW(DW)) u_dut_zero (
    .CLK       (CLK),
    .CLR       (CLR),
    .DIN       (DIN2),
    .DINF      (DINF2),
    .OUT_RDY   (1'b1),
    .DATA      (DATA2),
    .VALID     (VALID2),
    .ERR       (ERR2),
    .OVR       (OVR2),
    .FRM_CNT   (FRM_CNT2),
    .DBG_STATE (DBG_STATE2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned pack(input bit q[$]);
    int unsigned v = 0;
    foreach (q[i]) v = (v << 1) | 32'(q[i]);
    return v;
  endfunction

  function automatic void model_reset();
    m_hist.delete();
    m_bits.delete();
    m_in_data = 1'b0;
    m_data    = '0;
    m_valid   = 1'b0;
    m_err     = 1'b0;
    m_ovr     = 1'b0;
    m_frm     = 0;
  endfunction

  // One clock edge of the receiver, described in terms of bit history.
  function automatic void model_edge(input bit din, input bit dinf, input bit rdy);
    bit            was_valid = m_valid;
    bit            complete = 1'b0;
    logic [DW-1:0] word = '0;
    m_err = (din == dinf);
    if (din == dinf) begin
      m_hist.delete();
      m_bits.delete();
      m_in_data = 1'b0;
    end else if (!m_in_data) begin
      m_hist.push_back(din);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      if (m_hist.size() == 4 && pack(m_hist) == 32'(SYNC)) begin
        m_in_data = 1'b1;
        m_bits.delete();
      end
    end else begin
      m_bits.push_back(din);
      if (m_bits.size() == DW) begin
        complete  = 1'b1;
        word      = DW'(pack(m_bits));
        m_in_data = 1'b0;
        m_bits.delete();
        m_hist.delete();
      end
    end
    if (was_valid && rdy) begin
      m_frm++;
      m_valid = 1'b0;
    end
    if (complete) begin
      if (!was_valid || rdy) begin
        m_data  = word;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end
  endfunction

  task automatic compare_all();
    check("valid", VALID, m_valid);
    check("data", DATA, m_data);
    check("err", ERR, m_err);
    check("ovr", OVR, m_ovr);
    check("frm", FRM_CNT, 32'(m_frm % 16));
    check("state", DBG_STATE, m_in_data ? ST_DATA : ST_HUNT);
  endtask

  // driver tasks
  task automatic step(input bit din, input bit dinf, input bit rdy);
    DIN = din;
    DINF = dinf;
    OUT_RDY = rdy;
    if (sb_on && VALID && rdy)
      check("sb_word", DATA, (exp_q.size() > 0) ? exp_q.pop_front() : 'x);
    @(posedge CLK);
    #1;
    model_edge(din, dinf, rdy);
    compare_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, rdy);
  endtask

  task automatic send_sync(input bit rdy);
    logic [3:0] s = SYNC;
    for (int i = 3; i >= 0; i--) step(s[i], ~s[i], rdy);
  endtask

  task automatic send_frame(input logic [DW-1:0] w, input bit rdy, input bit rdy_last);
    send_sync(rdy);
    for (int i = DW - 1; i >= 0; i--) step(w[i], ~w[i], (i == 0) ? rdy_last : rdy);
  endtask

  task automatic pulse_clr();
    CLR = 1'b0;
    #2;
    model_reset();
    compare_all();
    CLR = 1'b1;
  endtask

  task automatic rand_bit(input bit b);
    bit bad = ($urandom_range(0, 29) == 0);
    bit rdy = ($urandom_range(0, 3) != 0);
    step(b, bad ? b : ~b, rdy);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    compare_all();
    CLR = 1'b1;

    // sync detect and load
    pulse_clr();
    send_frame(8'hA5, 1'b1, 1'b1);
    check("t1_valid", VALID, 1);
    check("t1_data", DATA, 8'hA5);
    idle(1, 1'b1);
    check("t1_frm", FRM_CNT, 1);
    check("t1_err", ERR, 0);
    check("t1_ovr", OVR, 0);

    // backpressure and overrun
    pulse_clr();
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0);
    check("t2_data", DATA, 8'h3C);
    check("t2_ovr", OVR, 1);
    check("t2_valid", VALID, 1);
    check("t2_frm", FRM_CNT, 0);

    // simultaneous accept and load
    pulse_clr();
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1);
    check("t3_data", DATA, 8'h22);
    check("t3_valid", VALID, 1);
    check("t3_frm", FRM_CNT, 1);
    check("t3_ovr", OVR, 0);
    idle(1, 1'b1);

    // complement violation on data bit 3
    pulse_clr();
    send_sync(1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("t4_err_hi", ERR, 1);
    idle(1, 1'b1);
    check("t4_err_lo", ERR, 0);
    idle(6, 1'b1);
    check("t4_no_word", VALID, 0);
    send_frame(8'h5A, 1'b1, 1'b1);
    check("t4_data", DATA, 8'h5A);
    check("t4_valid", VALID, 1);
    idle(1, 1'b1);

    // reset mid-frame
    pulse_clr();
    send_frame(8'h11, 1'b1, 1'b1);
    idle(1, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0);
    send_sync(1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    check("t5_pre_ovr", OVR, 1);
    check("t5_pre_frm", FRM_CNT, 1);
    DIN = 1'b0;
    DINF = 1'b1;
    #2;
    CLR = 1'b0;
    #1;
    model_reset();
    check("t5_valid", VALID, 0);
    check("t5_data", DATA, 0);
    check("t5_ovr", OVR, 0);
    check("t5_frm", FRM_CNT, 0);
    check("t5_state", DBG_STATE, ST_HUNT);
    @(posedge CLK);
    #1;
    compare_all();
    CLR = 1'b1;
    send_frame(8'h96, 1'b1, 1'b1);
    check("t5_fresh", DATA, 8'h96);
    idle(1, 1'b1);

    // frame counter wrap with scoreboard of accepted words
    pulse_clr();
    sb_on = 1'b1;
    for (int f = 0; f < 16; f++) begin
      logic [DW-1:0] w = DW'($urandom);
      exp_q.push_back(w);
      send_frame(w, 1'b1, 1'b1);
    end
    check("t6_frm15", FRM_CNT, 15);
    idle(1, 1'b1);
    check("t6_wrap", FRM_CNT, 0);
    check("t6_sb_drained", exp_q.size(), 0);
    sb_on = 1'b0;

    // zero sync: no match until four bits are in
    DIN2 = 1'b1;
    DINF2 = 1'b0;
    pulse_clr();
    DIN2 = 1'b0;
    DINF2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check("z_hunt", DBG_STATE2, ST_HUNT);
    end
    @(posedge CLK);
    #1;
    check("z_data", DBG_STATE2, ST_DATA);
    begin
      logic [DW-1:0] zw = 8'hC3;
      for (int i = DW - 1; i >= 0; i--) begin
        DIN2 = zw[i];
        DINF2 = ~zw[i];
        @(posedge CLK);
        #1;
        check("z_valid", VALID2, (i == 0) ? 1 : 0);
      end
      check("z_word", DATA2, zw);
      check("z_err", ERR2, 0);
    end

    // randomized stream with occasional illegal bits and random backpressure
    pulse_clr();
    for (int f = 0; f < 40; f++) begin
      int gap = $urandom_range(0, 3);
      logic [11:0] fr = {SYNC, DW'($urandom)};
      for (int g = 0; g < gap; g++) rand_bit(1'($urandom));
      for (int i = 11; i >= 0; i--) rand_bit(fr[i]);
    end
    idle(2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
